uart_tx_arbiter: RTL and testbench

Round-robin packet arbiter that shares the single UART transmit path (the XMIT FIFO write port) among up to N_REQ on-chip requesters, such as the error-count reporter and register-dump logic. Each requester presents a byte stream framed by a last flag. The arbiter grants one requester per packet, optionally prefixes a header byte carrying the requester ID, and writes bytes into the FIFO only while it is not full. A stalled requester is evicted after a timeout so the UART is never locked up.

---
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and XMIT-FIFO-side bus of the UART TX arbiter.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic               fifo_full;
    logic               fifo_wr;
    logic [7:0]         fifo_data;

    // master: the arbiter itself
    modport master (
        input  req, req_data, req_valid, req_last, fifo_full,
        output req_ready, grant, fifo_wr, fifo_data
    );

    // slave: requesters plus the FIFO
    modport slave (
        output req, req_data, req_valid, req_last, fifo_full,
        input  req_ready, grant, fifo_wr, fifo_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin packet arbiter feeding the UART XMIT FIFO, with
//            optional ID header and stalled-owner timeout eviction.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HDR_EN      = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic           clk,
    input  wire logic           gl_reset,
    uart_tx_arbiter_if.master   bus,
    output logic                busy,
    output logic                abort_pulse,
    output logic [7:0]          drop_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       C_HDR_TAG  = 4'hA;
    localparam logic [N_REQ-1:0] C_ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [N_REQ-1:0]   grant_q,    grant_d;
    logic [IDX_W-1:0]   gidx_q,     gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [TMO_W-1:0]   tmo_q,      tmo_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic               abort_q,    abort_d;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_next_ptr;
    int                 w_cand;
    int                 w_nxt;

    // First set req bit at or after rr_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = int'(rr_ptr_q) + k;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            if (!w_found && bus.req[IDX_W'(w_cand)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(w_cand);
            end
        end
        w_nxt = int'(w_win) + 1;
        if (w_nxt >= N_REQ) begin
            w_nxt = 0;
        end
        w_next_ptr = IDX_W'(w_nxt);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        tmo_d         = tmo_q;
        drop_cnt_d    = drop_cnt_q;
        abort_d       = 1'b0;
        bus.fifo_wr   = 1'b0;
        bus.fifo_data = 8'h00;
        bus.req_ready = '0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (w_found) begin
                    grant_d  = C_ONE << w_win;
                    gidx_d   = w_win;
                    rr_ptr_d = w_next_ptr;
                    state_d  = (HDR_EN != 0) ? S_HDR : S_DATA;
                end
            end

            S_HDR: begin
                tmo_d         = '0;
                bus.fifo_data = {C_HDR_TAG, 4'(gidx_q)};
                bus.fifo_wr   = !bus.fifo_full;
                if (!bus.fifo_full) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                bus.req_ready[gidx_q] = !bus.fifo_full;
                bus.fifo_wr           = bus.req_valid[gidx_q] & !bus.fifo_full;
                bus.fifo_data         = bus.req_data[{gidx_q, 3'b000} +: 8];
                if (bus.fifo_wr) begin
                    tmo_d = '0;
                    if (bus.req_last[gidx_q]) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    // Stalled owner: release the UART, keep whatever was written.
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    tmo_d      = '0;
                    abort_d    = 1'b1;
                    drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge gl_reset) begin
        if (!gl_reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            tmo_q      <= '0;
            drop_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            tmo_q      <= tmo_d;
            drop_cnt_q <= drop_cnt_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.grant   = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign abort_pulse = abort_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter (N_REQ=4,
//            header on, TIMEOUT_CYC=16). Inputs change on negedge, checks #1 later.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    logic       clk;
    logic       gl_reset;
    logic       busy;
    logic       abort_pulse;
    logic [7:0] drop_cnt;
    int         n_cmp;
    int         n_err;

    uart_tx_arbiter_if #(.N_REQ(4)) bus ();

    uart_tx_arbiter #(
        .N_REQ       (4),
        .HDR_EN      (1),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .gl_reset    (gl_reset),
        .bus         (bus.master),
        .busy        (busy),
        .abort_pulse (abort_pulse),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        gl_reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        gl_reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({bus.grant, bus.req_ready, bus.fifo_wr, busy, abort_pulse, drop_cnt} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_state: grant=%b ready=%b wr=%b busy=%b abort=%b drop=%0d, want all 0",
                     bus.grant, bus.req_ready, bus.fifo_wr, busy, abort_pulse, drop_cnt);
        end
    endtask

    // Requester 1 sends 0x11,0x22,0x33; expect A1 then the three bytes back to back.
    task automatic test_single();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        @(negedge clk);
        bus.req[1] = 1'b1; bus.req_valid[1] = 1'b1; bus.req_data[15:8] = exp_b[0];
        #1;
        n_cmp++;
        if (bus.fifo_wr !== 1'b0) begin
            n_err++; $display("FAIL single_arb_cycle: fifo_wr=%b want 0", bus.fifo_wr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.grant !== 4'b0010 || bus.fifo_wr !== 1'b1 || bus.fifo_data !== 8'hA1) begin
            n_err++;
            $display("FAIL single_hdr: grant=%b wr=%b data=%h want 0010/1/a1", bus.grant, bus.fifo_wr, bus.fifo_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_data[15:8] = exp_b[i];
            bus.req_last[1]    = (i == 2);
            #1;
            n_cmp++;
            if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== exp_b[i] || bus.req_ready !== 4'b0010) begin
                n_err++;
                $display("FAIL single_byte%0d: wr=%b data=%h ready=%b want 1/%h/0010",
                         i, bus.fifo_wr, bus.fifo_data, bus.req_ready, exp_b[i]);
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.grant !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_release: grant=%b busy=%b want 0000/0", bus.grant, busy);
        end
    endtask

    // Requesters 0 and 2 both hold single-byte packets; rr_ptr starts at 0.
    task automatic test_round_robin();
        int exp_id [4];
        exp_id[0] = 0; exp_id[1] = 2; exp_id[2] = 0; exp_id[3] = 2;
        do_reset();
        @(negedge clk);
        bus.req       = 4'b0101;
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b0101;
        bus.req_data  = {8'h53, 8'h52, 8'h51, 8'h50};
        for (int p = 0; p < 4; p++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (bus.grant !== (4'b0001 << exp_id[p]) || bus.fifo_wr !== 1'b1 ||
                bus.fifo_data !== (8'hA0 + 8'(exp_id[p]))) begin
                n_err++;
                $display("FAIL rr_hdr%0d: grant=%b wr=%b data=%h want id %0d header",
                         p, bus.grant, bus.fifo_wr, bus.fifo_data, exp_id[p]);
            end
            @(negedge clk); #1;
            n_cmp++;
            if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== (8'h50 + 8'(exp_id[p]))) begin
                n_err++;
                $display("FAIL rr_data%0d: wr=%b data=%h want 1/%h",
                         p, bus.fifo_wr, bus.fifo_data, 8'h50 + 8'(exp_id[p]));
            end
            @(negedge clk);
            if (p == 3) clear_inputs();
            #1;
            n_cmp++;
            if (bus.grant !== 4'b0000 || busy !== 1'b0 || bus.fifo_wr !== 1'b0) begin
                n_err++;
                $display("FAIL rr_dead%0d: grant=%b busy=%b wr=%b want 0/0/0", p, bus.grant, busy, bus.fifo_wr);
            end
        end
    endtask

    // FIFO full for 5 cycles mid-packet; owner drops req, an idle requester shows valid.
    task automatic test_fifo_full();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hC0; exp_b[1] = 8'hC1; exp_b[2] = 8'hC2; exp_b[3] = 8'hC3;
        @(negedge clk);
        bus.req[1] = 1'b1; bus.req_valid = 4'b0110; bus.req_data[15:8] = exp_b[0];
        bus.req_data[23:16] = 8'hEE;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== 8'hA1) begin
            n_err++; $display("FAIL full_hdr: wr=%b data=%h want 1/a1", bus.fifo_wr, bus.fifo_data);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.req_data[15:8] = exp_b[i];
            #1;
            n_cmp++;
            if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== exp_b[i] || bus.req_ready !== 4'b0010) begin
                n_err++;
                $display("FAIL full_pre%0d: wr=%b data=%h ready=%b want 1/%h/0010",
                         i, bus.fifo_wr, bus.fifo_data, bus.req_ready, exp_b[i]);
            end
        end
        @(negedge clk);
        bus.req_data[15:8] = exp_b[2];
        bus.fifo_full      = 1'b1;
        bus.req[1]         = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (bus.fifo_wr !== 1'b0 || bus.req_ready !== 4'b0000 || busy !== 1'b1 || bus.grant !== 4'b0010) begin
                n_err++;
                $display("FAIL full_stall%0d: wr=%b ready=%b busy=%b grant=%b want 0/0000/1/0010",
                         c, bus.fifo_wr, bus.req_ready, busy, bus.grant);
            end
        end
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            bus.fifo_full      = 1'b0;
            bus.req_data[15:8] = exp_b[i];
            bus.req_last[1]    = (i == 3);
            #1;
            n_cmp++;
            if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== exp_b[i] || bus.req_ready !== 4'b0010) begin
                n_err++;
                $display("FAIL full_post%0d: wr=%b data=%h ready=%b want 1/%h/0010",
                         i, bus.fifo_wr, bus.fifo_data, bus.req_ready, exp_b[i]);
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.grant !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL full_release: grant=%b busy=%b want 0000/0", bus.grant, busy);
        end
    endtask

    // Requester 3 stalls (rr_ptr=2 here); evicted after 16 idle cycles, then 0 wins.
    task automatic test_timeout();
        int n_abort;
        bit done;
        @(negedge clk);
        bus.req = 4'b1001;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.grant !== 4'b1000 || bus.fifo_data !== 8'hA3 || bus.fifo_wr !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_hdr: grant=%b wr=%b data=%h want 1000/1/a3", bus.grant, bus.fifo_wr, bus.fifo_data);
        end
        repeat (16) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.grant !== 4'b1000 || abort_pulse !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_16th_idle: grant=%b abort=%b busy=%b want 1000/0/1", bus.grant, abort_pulse, busy);
        end
        @(negedge clk);
        bus.req = 4'b0001;
        #1;
        n_cmp++;
        if (bus.grant !== 4'b0000 || busy !== 1'b0 || abort_pulse !== 1'b1 || drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL tmo_abort: grant=%b busy=%b abort=%b drop=%0d want 0000/0/1/1",
                     bus.grant, busy, abort_pulse, drop_cnt);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.grant !== 4'b0001 || abort_pulse !== 1'b0) begin
            n_err++; $display("FAIL tmo_next_grant: grant=%b abort=%b want 0001/0", bus.grant, abort_pulse);
        end
        n_abort = 1;
        done    = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(negedge clk); #1;
            if (abort_pulse === 1'b1) n_abort++;
            if (n_abort == 257) done = 1'b1;
        end
        n_cmp++;
        if (n_abort != 257 || drop_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL tmo_saturate: aborts=%0d drop=%0d want 257/255", n_abort, drop_cnt);
        end
        @(negedge clk);
        clear_inputs();
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk); #1;
            if (busy === 1'b0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL tmo_drain: busy=%b want 0 within 40 cycles", busy);
        end
    endtask

    // Reset asserted mid-DATA between clock edges, then requester 3 wins first.
    task automatic test_reset_mid();
        @(negedge clk);
        bus.req[1] = 1'b1; bus.req_valid[1] = 1'b1; bus.req_data[15:8] = 8'h77;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || bus.fifo_wr !== 1'b1 || bus.fifo_data !== 8'h77) begin
            n_err++;
            $display("FAIL rstmid_pre: busy=%b wr=%b data=%h want 1/1/77", busy, bus.fifo_wr, bus.fifo_data);
        end
        gl_reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.grant, bus.req_ready, bus.fifo_wr, busy, abort_pulse, drop_cnt} !== 19'd0) begin
            n_err++;
            $display("FAIL rstmid_async: grant=%b ready=%b wr=%b busy=%b abort=%b drop=%0d want all 0",
                     bus.grant, bus.req_ready, bus.fifo_wr, busy, abort_pulse, drop_cnt);
        end
        @(negedge clk);
        clear_inputs();
        bus.req[3] = 1'b1; bus.req_valid[3] = 1'b1; bus.req_data[31:24] = 8'h3C;
        @(negedge clk);
        gl_reset = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.grant !== 4'b1000 || bus.fifo_wr !== 1'b1 || bus.fifo_data !== 8'hA3) begin
            n_err++;
            $display("FAIL rstmid_first_grant: grant=%b wr=%b data=%h want 1000/1/a3",
                     bus.grant, bus.fifo_wr, bus.fifo_data);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        gl_reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
